pcie_dma_fifo: RTL and testbench

Parametrised synchronous FIFO for the PCIe DMA datapath. It replaces the fixed 64-bit TX/RX FIFO widths with a configurable data width and an optional strobe field. It adds packet accounting (count of `last` beats), a store-and-forward mode, an almost-full threshold and a synchronous flush. The same module is instantiated on the DMA TX path (strobes on) and RX path (strobes off), between the PCIe core AXI-stream side and the DMA engine.

---
 rtl/pcie_dma_pkg.sv | 18 +
 rtl/pcie_dma_fifo_ram.sv | 32 +++
 rtl/pcie_dma_fifo.sv | 134 +++++++++++++
 tb/tb_pcie_dma_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared constants and helpers for the PCIe DMA datapath.
//   pcie_dma_fifo_width() - packed FIFO entry width {last, [strob], data}.
//   TXFIFO_WIDTH / RXFIFO_WIDTH - entry widths of the default TX (strobes) and
//   RX (no strobes) FIFOs.
package pcie_dma_pkg;

    localparam int PCIE_DMA_DW_DEFAULT    = 64;
    localparam int PCIE_DMA_ABITS_DEFAULT = 4;

    // Entry width: data, optional one strobe bit per byte, one last bit.
    function automatic int pcie_dma_fifo_width(input int dw, input int has_strob);
        return dw + has_strob * dw / 8 + 1;
    endfunction

    localparam int TXFIFO_WIDTH = pcie_dma_fifo_width(PCIE_DMA_DW_DEFAULT, 1);
    localparam int RXFIFO_WIDTH = pcie_dma_fifo_width(PCIE_DMA_DW_DEFAULT, 0);

endpackage

// File: rtl/pcie_dma_fifo_ram.sv
// pcie_dma_fifo_ram: one write port, one asynchronous read port storage array.
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write entry
//   i_raddr - read address
//   o_rdata - entry at i_raddr (combinational)
// Contents are deliberately not reset so the array maps onto distributed RAM.
module pcie_dma_fifo_ram #(
    parameter int WIDTH = 73,
    parameter int ABITS = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ABITS-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [ABITS-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ABITS];

    // Storage write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pcie_dma_fifo.sv
// pcie_dma_fifo: parametrised first-word-fall-through FIFO for the DMA TX/RX
// paths, with packet accounting, optional store-and-forward and flush.
//   i_clk, i_rst (async, active-high), i_flush (synchronous clear)
//   write side : i_wvalid, o_wready, i_wdata, i_wstrob, i_wlast
//   read side  : o_rvalid, i_rready, o_rdata, o_rstrob, o_rlast
//   status     : o_count (beats), o_pkt_count (complete packets), o_almost_full
module pcie_dma_fifo
    import pcie_dma_pkg::*;
#(
    parameter int DATA_WIDTH  = PCIE_DMA_DW_DEFAULT,
    parameter int HAS_STROB   = 1,
    parameter int ABITS       = PCIE_DMA_ABITS_DEFAULT,
    parameter int STORE_FWD   = 0,
    parameter int AFULL_LEVEL = (2**ABITS) - 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrob,
    input  logic                    i_wlast,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [DATA_WIDTH/8-1:0] o_rstrob,
    output logic                    o_rlast,
    output logic [ABITS:0]          o_count,
    output logic [ABITS:0]          o_pkt_count,
    output logic                    o_almost_full
);

    localparam int              SW      = DATA_WIDTH / 8;
    localparam int              EW      = pcie_dma_fifo_width(DATA_WIDTH, HAS_STROB);
    localparam logic [ABITS:0]  L_DEPTH = (ABITS+1)'(2**ABITS);
    localparam logic [ABITS:0]  L_AFULL = (ABITS+1)'(AFULL_LEVEL);
    localparam logic [ABITS:0]  L_ONE   = (ABITS+1)'(1);
    localparam logic [ABITS-1:0] L_PONE = (ABITS)'(1);

    logic [ABITS-1:0] r_wr_ptr;
    logic [ABITS-1:0] r_rd_ptr;
    logic [ABITS:0]   r_count;
    logic [ABITS:0]   r_pkt_count;
    logic [ABITS:0]   w_count_nxt;
    logic [ABITS:0]   w_pkt_nxt;
    logic [EW-1:0]    w_wentry;
    logic [EW-1:0]    w_rentry;
    logic             w_full;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_full   = (r_count == L_DEPTH);
    // Only registered count gates writes: a full FIFO refuses a write even
    // when a read frees a slot in the same cycle.
    assign o_wready = ~w_full;
    // In store-and-forward mode the full fallback lets a packet longer than
    // the FIFO cut through instead of deadlocking.
    assign o_rvalid = (STORE_FWD != 0) ? ((r_pkt_count != '0) | w_full)
                                       : (r_count != '0);
    assign w_wr_en  = i_wvalid & o_wready;
    assign w_rd_en  = o_rvalid & i_rready;

    assign o_count       = r_count;
    assign o_pkt_count   = r_pkt_count;
    assign o_almost_full = (r_count >= L_AFULL);

    if (HAS_STROB != 0) begin : g_strob
        assign w_wentry = {i_wlast, i_wstrob, i_wdata};
        assign o_rstrob = w_rentry[DATA_WIDTH +: SW];
    end else begin : g_nostrob
        logic w_unused_strob;
        assign w_wentry       = {i_wlast, i_wdata};
        assign o_rstrob       = {SW{1'b1}};
        assign w_unused_strob = ^i_wstrob;
    end

    assign o_rdata = w_rentry[DATA_WIDTH-1:0];
    assign o_rlast = w_rentry[EW-1];

    // A flushed-cycle write is dropped, so the array is not touched either.
    pcie_dma_fifo_ram #(
        .WIDTH (EW),
        .ABITS (ABITS)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_en & ~i_flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wentry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rentry)
    );

    // Next beat and packet counts; simultaneous inc/dec cancel.
    always_comb begin
        w_count_nxt = r_count;
        w_pkt_nxt   = r_pkt_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + L_ONE;
            2'b01:   w_count_nxt = r_count - L_ONE;
            default: w_count_nxt = r_count;
        endcase
        case ({w_wr_en & i_wlast, w_rd_en & o_rlast})
            2'b10:   w_pkt_nxt = r_pkt_count + L_ONE;
            2'b01:   w_pkt_nxt = r_pkt_count - L_ONE;
            default: w_pkt_nxt = r_pkt_count;
        endcase
    end

    // Pointer and counter state; flush overrides any same-cycle transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + L_PONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + L_PONE;
            end
            r_count     <= w_count_nxt;
            r_pkt_count <= w_pkt_nxt;
        end
    end

endmodule

// File: tb/tb_pcie_dma_fifo.sv
// tb_pcie_dma_fifo: randomized self-checking bench. Two instances share the
// stimulus: u_dut0 (64-bit, strobes, cut-through) and u_dut1 (128-bit, no
// strobes, store-and-forward). A queue of beats is the reference model.
module tb_pcie_dma_fifo;

    typedef struct packed {
        logic         last;
        logic [15:0]  strob;
        logic [127:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         sel = 1'b0;
    logic         wvalid = 1'b0;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrob = '0;
    logic         wlast = 1'b0;
    logic         rready = 1'b0;

    logic        d0_wready, d0_rvalid, d0_rlast, d0_afull;
    logic [63:0] d0_rdata;
    logic [7:0]  d0_rstrob;
    logic [4:0]  d0_count, d0_pkt;
    logic         d1_wready, d1_rvalid, d1_rlast, d1_afull;
    logic [127:0] d1_rdata;
    logic [15:0]  d1_rstrob;
    logic [4:0]   d1_count, d1_pkt;

    beat_t q[$];
    int    n_checks = 0;
    int    n_errs = 0;

    always #5 clk = ~clk;

    pcie_dma_fifo #(.DATA_WIDTH(64), .HAS_STROB(1), .ABITS(4), .STORE_FWD(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_wvalid(wvalid & ~sel), .o_wready(d0_wready),
        .i_wdata(wdata[63:0]), .i_wstrob(wstrob[7:0]), .i_wlast(wlast),
        .o_rvalid(d0_rvalid), .i_rready(rready & ~sel),
        .o_rdata(d0_rdata), .o_rstrob(d0_rstrob), .o_rlast(d0_rlast),
        .o_count(d0_count), .o_pkt_count(d0_pkt), .o_almost_full(d0_afull)
    );

    pcie_dma_fifo #(.DATA_WIDTH(128), .HAS_STROB(0), .ABITS(4), .STORE_FWD(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_wvalid(wvalid & sel), .o_wready(d1_wready),
        .i_wdata(wdata), .i_wstrob(wstrob), .i_wlast(wlast),
        .o_rvalid(d1_rvalid), .i_rready(rready & sel),
        .o_rdata(d1_rdata), .o_rstrob(d1_rstrob), .o_rlast(d1_rlast),
        .o_count(d1_count), .o_pkt_count(d1_pkt), .o_almost_full(d1_afull)
    );

    logic         obs_wready, obs_rvalid, obs_rlast, obs_afull;
    logic [127:0] obs_rdata;
    logic [15:0]  obs_rstrob;
    logic [4:0]   obs_count, obs_pkt;

    assign obs_wready = sel ? d1_wready : d0_wready;
    assign obs_rvalid = sel ? d1_rvalid : d0_rvalid;
    assign obs_rlast  = sel ? d1_rlast  : d0_rlast;
    assign obs_afull  = sel ? d1_afull  : d0_afull;
    assign obs_rdata  = sel ? d1_rdata  : {64'h0, d0_rdata};
    assign obs_rstrob = sel ? d1_rstrob : {8'h0, d0_rstrob};
    assign obs_count  = sel ? d1_count  : d0_count;
    assign obs_pkt    = sel ? d1_pkt    : d0_pkt;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rules derived from the stored beats.
    function automatic int m_pkts();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    function automatic bit m_wready();
        return q.size() != 16;
    endfunction

    function automatic bit m_rvalid();
        if (sel) return (m_pkts() != 0) || (q.size() == 16);
        return q.size() != 0;
    endfunction

    // One clock: check outputs mid-cycle, then apply the cycle's effect to the model.
    task automatic step();
        bit    acc_w, acc_r;
        beat_t b;
        @(negedge clk);
        check_eq("wready", obs_wready, m_wready());
        check_eq("rvalid", obs_rvalid, m_rvalid());
        check_eq("count", obs_count, q.size());
        check_eq("pkt_count", obs_pkt, m_pkts());
        check_eq("almost_full", obs_afull, q.size() >= 14);
        check_eq("count_max", obs_count <= 5'd16, 1'b1);
        if (m_rvalid()) begin
            check_eq("rdata", obs_rdata, q[0].data);
            check_eq("rstrob", obs_rstrob, q[0].strob);
            check_eq("rlast", obs_rlast, q[0].last);
        end
        acc_w = wvalid && m_wready();
        acc_r = rready && m_rvalid();
        b.last  = wlast;
        b.strob = sel ? 16'hFFFF : {8'h0, wstrob[7:0]};
        b.data  = sel ? wdata : {64'h0, wdata[63:0]};
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (acc_r) void'(q.pop_front());
            if (acc_w) q.push_back(b);
        end
    endtask

    task automatic idle();
        wvalid = 1'b0; rready = 1'b0; wlast = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        idle();
        rready = 1'b1;
        while (q.size() != 0 && cyc < 200) begin
            step();
            cyc++;
        end
        check_eq(tag, q.size(), 0);
        rready = 1'b0;
    endtask

    initial begin
        int idx;
        int cyc;

        // Reset state on the default instance.
        idle();
        #2;
        check_eq("rst_wready", d0_wready, 1'b1);
        check_eq("rst_rvalid", d0_rvalid, 1'b0);
        check_eq("rst_count", d0_count, 5'd0);
        check_eq("rst_pkt", d0_pkt, 5'd0);
        do_reset();
        step();

        // Asynchronous reset with five beats stored.
        wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 128'($urandom); wstrob = 16'($urandom); wlast = (i == 2);
            step();
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_count", d0_count, 5'd0);
        check_eq("arst_pkt", d0_pkt, 5'd0);
        check_eq("arst_rvalid", d0_rvalid, 1'b0);
        check_eq("arst_wready", d0_wready, 1'b1);
        #1;
        rst = 1'b0;
        q.delete();
        step();

        // Fill to full, then a same-cycle read and write while full.
        wvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = {$urandom, $urandom, $urandom, $urandom}; wstrob = 16'($urandom);
            wlast = ($urandom_range(3) == 0);
            step();
        end
        check_eq("full_count", d0_count, 5'd16);
        check_eq("full_wready", d0_wready, 1'b0);
        rready = 1'b1;
        wdata = 128'h1234;
        step();
        check_eq("full_rw_count", d0_count, 5'd15);
        drain("fill_drain");

        // Ordered transfer across pointer wrap with random handshakes.
        idx = 0; cyc = 0;
        while ((idx < 40 || q.size() != 0) && cyc < 2000) begin
            wvalid = (idx < 40) && ($urandom_range(3) != 0);
            wdata  = 128'(idx);
            wstrob = 16'(idx[7:0]);
            wlast  = (idx % 5 == 4);
            rready = ($urandom_range(2) != 0);
            if (wvalid && m_wready()) idx++;
            step();
            cyc++;
        end
        check_eq("wrap_done", (idx == 40) && (q.size() == 0), 1'b1);

        // Flush with 7 beats / 2 packets stored and a simultaneous write.
        do_reset();
        wvalid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wdata = 128'($urandom); wstrob = 16'($urandom); wlast = (i == 2 || i == 6);
            step();
        end
        check_eq("pre_flush_pkt", d0_pkt, 5'd2);
        flush = 1'b1; wdata = 128'hDEAD; wlast = 1'b0;
        step();
        idle();
        check_eq("flush_count", d0_count, 5'd0);
        check_eq("flush_pkt", d0_pkt, 5'd0);
        check_eq("flush_rvalid", d0_rvalid, 1'b0);
        wvalid = 1'b1; wdata = 128'hBEEF; wstrob = 16'h5A; wlast = 1'b1;
        step();
        idle();
        check_eq("post_flush_data", d0_rdata, 64'hBEEF);
        drain("flush_drain");

        // Store-and-forward instance: 3-beat packet.
        sel = 1'b1;
        do_reset();
        check_eq("nostrob_ones", d1_rstrob, 16'hFFFF);
        rready = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = {$urandom, $urandom, $urandom, $urandom}; wlast = (i == 2);
            step();
        end
        wvalid = 1'b0;
        check_eq("sf_pkt_ready", d1_pkt, 5'd1);
        check_eq("sf_rvalid_after_last", d1_rvalid, 1'b1);
        drain("sf_drain");
        check_eq("sf_pkt_zero", d1_pkt, 5'd0);

        // Store-and-forward cut-through on a 20-beat packet.
        idx = 0; cyc = 0;
        rready = 1'b1;
        while ((idx < 20 || q.size() != 0) && cyc < 500) begin
            wvalid = (idx < 20);
            wdata  = {$urandom, $urandom, $urandom, 32'(idx)};
            wlast  = (idx == 19);
            if (wvalid && m_wready()) idx++;
            step();
            cyc++;
        end
        check_eq("sf_long_done", (idx == 20) && (q.size() == 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
